// File: rtl/ram_ctrl_if.sv
// Request bus and array-side signals between a requester and the ram_ctrl
// sequencer for an 8x8 SRAM array.
interface ram_ctrl_if;
    logic       req;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] sa_q;
    logic       ready;
    logic [2:0] dec_a;
    logic       dec_en;
    logic       pre;
    logic       wen;
    logic [7:0] din;
    logic       sae;
    logic [7:0] rdata;
    logic       rvalid;
    logic       wdone;

    modport slave (
        input  req, we, addr, wdata, sa_q,
        output ready, dec_a, dec_en, pre, wen, din, sae, rdata, rvalid, wdone
    );

    modport master (
        output req, we, addr, wdata, sa_q,
        input  ready, dec_a, dec_en, pre, wen, din, sae, rdata, rvalid, wdone
    );
endinterface

// File: rtl/ram_ctrl.sv
// SRAM access sequencer: precharge, wordline, sense, done.
// All array controls are decoded from the registered state only.
module ram_ctrl #(
    parameter int unsigned PRE_CYC = 1,
    parameter int unsigned WL_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        SENSE,
        DONE
    } state_t;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] addr_q;
    logic       we_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;

    logic       ready_d, dec_en_d, pre_d, wen_d, sae_d, rvalid_d, wdone_d;

    // State register, request latch and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                we_q    <= bus.we;
                wdata_q <= bus.wdata;
            end
            if (state_q == SENSE) begin
                rdata_q <= bus.sa_q;
            end
        end
    end

    // Next-state with phase-counter reload on entry, and Moore output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        dec_en_d = 1'b0;
        pre_d    = 1'b0;
        wen_d    = 1'b0;
        sae_d    = 1'b0;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req) begin
                    state_d = PRE;
                    cnt_d   = PRE_LOAD;
                end
            end
            PRE: begin
                pre_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ACT;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACT: begin
                dec_en_d = 1'b1;
                wen_d    = we_q;
                if (cnt_q == 4'd0) begin
                    state_d = we_q ? DONE : SENSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SENSE: begin
                dec_en_d = 1'b1;
                sae_d    = 1'b1;
                state_d  = DONE;
                cnt_d    = '0;
            end
            DONE: begin
                rvalid_d = ~we_q;
                wdone_d  = we_q;
                state_d  = IDLE;
                cnt_d    = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ready  = ready_d;
    assign bus.dec_a  = addr_q;
    assign bus.dec_en = dec_en_d;
    assign bus.pre    = pre_d;
    assign bus.wen    = wen_d;
    assign bus.din    = wdata_q;
    assign bus.sae    = sae_d;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_d;
    assign bus.wdone  = wdone_d;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: default timing instance plus a PRE_CYC=3,
// WL_CYC=1 instance sharing clock and reset.
module tb_ram_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_ctrl_if b1 ();
    ram_ctrl_if b2 ();

    ram_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    ram_ctrl #(
        .PRE_CYC (3),
        .WL_CYC  (1)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    logic [25:0] outs1, outs2;
    localparam logic [25:0] RST_OUTS = {1'b1, 25'd0};
    assign outs1 = {b1.ready, b1.dec_a, b1.dec_en, b1.pre, b1.wen, b1.din,
                    b1.sae, b1.rdata, b1.rvalid, b1.wdone};
    assign outs2 = {b2.ready, b2.dec_a, b2.dec_en, b2.pre, b2.wen, b2.din,
                    b2.sae, b2.rdata, b2.rvalid, b2.wdone};

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b1.req = 1'b1; b1.we = 1'b0; b1.addr = 3'd6; b1.wdata = 8'h5E; b1.sa_q = 8'h00;
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 3'd1; b2.wdata = 8'h12; b2.sa_q = 8'h00;
        tick();
        tick();
        checks++;
        if (outs1 !== RST_OUTS) begin
            failures++;
            $display("FAIL reset_outs1: got %h required %h", outs1, RST_OUTS);
        end
        checks++;
        if (outs2 !== RST_OUTS) begin
            failures++;
            $display("FAIL reset_outs2: got %h required %h", outs2, RST_OUTS);
        end
        b1.req = 1'b0; b2.req = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (b1.ready !== 1'b1 || b1.pre !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept: ready=%b pre=%b required 1 0", b1.ready, b1.pre);
        end
    endtask

    task automatic test_write();
        b1.req = 1'b1; b1.we = 1'b1; b1.addr = 3'd5; b1.wdata = 8'hA5;
        tick();  // T+1
        b1.req = 1'b0; b1.we = 1'b0; b1.wdata = 8'h00;
        checks++;
        if (b1.pre !== 1'b1 || b1.ready !== 1'b0 || b1.dec_en !== 1'b0) begin
            failures++;
            $display("FAIL write_pre: pre=%b ready=%b dec_en=%b required 1 0 0",
                     b1.pre, b1.ready, b1.dec_en);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if ({b1.pre, b1.dec_en, b1.wen, b1.dec_a, b1.din, b1.wdone} !==
                {1'b0, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b0}) begin
                failures++;
                $display("FAIL write_act_T+%0d: pre=%b dec_en=%b wen=%b dec_a=%0d din=%h wdone=%b required 0 1 1 5 a5 0",
                         c, b1.pre, b1.dec_en, b1.wen, b1.dec_a, b1.din, b1.wdone);
            end
        end
        tick();  // T+4
        checks++;
        if (b1.wdone !== 1'b1 || b1.rvalid !== 1'b0 || b1.dec_en !== 1'b0 || b1.wen !== 1'b0) begin
            failures++;
            $display("FAIL write_done: wdone=%b rvalid=%b dec_en=%b wen=%b required 1 0 0 0",
                     b1.wdone, b1.rvalid, b1.dec_en, b1.wen);
        end
        tick();  // T+5
        checks++;
        if (b1.wdone !== 1'b0 || b1.ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready: wdone=%b ready=%b required 0 1", b1.wdone, b1.ready);
        end
    endtask

    task automatic test_read();
        b1.sa_q = 8'h00;
        b1.req = 1'b1; b1.we = 1'b0; b1.addr = 3'd5; b1.wdata = 8'h00;
        tick();  // T+1
        b1.req = 1'b0;
        tick();  // T+2
        tick();  // T+3
        checks++;
        if (b1.dec_en !== 1'b1 || b1.wen !== 1'b0 || b1.sae !== 1'b0) begin
            failures++;
            $display("FAIL read_act: dec_en=%b wen=%b sae=%b required 1 0 0", b1.dec_en, b1.wen, b1.sae);
        end
        b1.sa_q = 8'hC3;
        tick();  // T+4
        checks++;
        if (b1.sae !== 1'b1 || b1.dec_en !== 1'b1 || b1.pre !== 1'b0 || b1.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL read_sense: sae=%b dec_en=%b pre=%b rvalid=%b required 1 1 0 0",
                     b1.sae, b1.dec_en, b1.pre, b1.rvalid);
        end
        b1.sa_q = 8'h3C;
        tick();  // T+5
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 8'h3C || b1.wdone !== 1'b0 || b1.sae !== 1'b0) begin
            failures++;
            $display("FAIL read_rvalid: rvalid=%b rdata=%h wdone=%b sae=%b required 1 3c 0 0",
                     b1.rvalid, b1.rdata, b1.wdone, b1.sae);
        end
        b1.sa_q = 8'hFF;
        tick();  // T+6
        checks++;
        if (b1.ready !== 1'b1 || b1.rvalid !== 1'b0 || b1.rdata !== 8'h3C) begin
            failures++;
            $display("FAIL read_hold: ready=%b rvalid=%b rdata=%h required 1 0 3c",
                     b1.ready, b1.rvalid, b1.rdata);
        end
    endtask

    task automatic test_ignore_inputs();
        b1.req = 1'b1; b1.we = 1'b1; b1.addr = 3'd5; b1.wdata = 8'h5A;
        tick();  // T+1
        b1.req = 1'b0;
        tick();  // T+2, ACT
        b1.addr = 3'd2; b1.req = 1'b1; b1.we = 1'b0; b1.wdata = 8'h11;
        tick();  // T+3
        b1.req = 1'b0;
        checks++;
        if (b1.dec_a !== 3'd5 || b1.din !== 8'h5A || b1.wen !== 1'b1) begin
            failures++;
            $display("FAIL ignore_latched: dec_a=%0d din=%h wen=%b required 5 5a 1",
                     b1.dec_a, b1.din, b1.wen);
        end
        tick();  // T+4
        checks++;
        if (b1.wdone !== 1'b1 || b1.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL ignore_wdone: wdone=%b rvalid=%b required 1 0", b1.wdone, b1.rvalid);
        end
        tick();  // T+5
        tick();  // T+6
        checks++;
        if (b1.ready !== 1'b1 || b1.pre !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_second: ready=%b pre=%b required 1 0", b1.ready, b1.pre);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        b1.req = 1'b1; b1.we = 1'b1; b1.addr = 3'd3; b1.wdata = 8'h77;
        tick();  // T+1
        b1.req = 1'b0;
        tick();  // T+2, ACT
        checks++;
        if (b1.dec_en !== 1'b1 || b1.wen !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_act: dec_en=%b wen=%b required 1 1", b1.dec_en, b1.wen);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (outs1 !== RST_OUTS) begin
            failures++;
            $display("FAIL abort_outs: got %h required %h", outs1, RST_OUTS);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b1.wdone !== 1'b0 || b1.ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: activity_seen=%b required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_cnt = 0;
        int rdy_idx = -1;
        int rv_n = 0;
        int rv_idx[2] = '{-1, -1};
        logic [7:0] rv_dat[2] = '{8'h00, 8'h00};
        b1.req = 1'b1; b1.we = 1'b0; b1.addr = 3'd0; b1.sa_q = 8'h11;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (b1.ready === 1'b1 && i <= 10) begin
                rdy_cnt++;
                rdy_idx = i;
            end
            if (b1.rvalid === 1'b1) begin
                if (rv_n < 2) begin
                    rv_idx[rv_n] = i;
                    rv_dat[rv_n] = b1.rdata;
                end
                rv_n++;
            end
            if (i == 1) b1.addr = 3'd7;
            if (i == 7) begin
                b1.req  = 1'b0;
                b1.sa_q = 8'h22;
            end
            if (i == 8) begin
                checks++;
                if (b1.dec_a !== 3'd7) begin
                    failures++;
                    $display("FAIL b2b_addr: dec_a=%0d required 7", b1.dec_a);
                end
            end
        end
        checks++;
        if (rdy_cnt != 1 || rdy_idx != 6) begin
            failures++;
            $display("FAIL b2b_ready_gap: ready_cycles=%0d at=%0d required 1 at 6", rdy_cnt, rdy_idx);
        end
        checks++;
        if (rv_n != 2 || rv_idx[0] != 5 || rv_idx[1] != 11) begin
            failures++;
            $display("FAIL b2b_rvalid: pulses=%0d at %0d,%0d required 2 at 5,11",
                     rv_n, rv_idx[0], rv_idx[1]);
        end
        checks++;
        if (rv_dat[0] !== 8'h11 || rv_dat[1] !== 8'h22) begin
            failures++;
            $display("FAIL b2b_rdata: got %h,%h required 11,22", rv_dat[0], rv_dat[1]);
        end
    endtask

    task automatic test_params();
        int pre_cnt = 0;
        int pre_last = -1;
        int act_cnt = 0;
        int overlap = 0;
        int rv_n = 0;
        int rv_at = -1;
        b2.req = 1'b1; b2.we = 1'b0; b2.addr = 3'd4; b2.sa_q = 8'h99;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) b2.req = 1'b0;
            if (b2.pre === 1'b1) begin
                pre_cnt++;
                pre_last = i;
            end
            if (b2.dec_en === 1'b1 && b2.sae === 1'b0) act_cnt++;
            if (b2.pre === 1'b1 && (b2.dec_en === 1'b1 || b2.wen === 1'b1 || b2.sae === 1'b1)) overlap++;
            if (b2.rvalid === 1'b1) begin
                rv_n++;
                rv_at = i;
            end
        end
        checks++;
        if (pre_cnt != 3 || pre_last != 3) begin
            failures++;
            $display("FAIL p_pre: pre_cycles=%0d last=%0d required 3 last 3", pre_cnt, pre_last);
        end
        checks++;
        if (act_cnt != 1) begin
            failures++;
            $display("FAIL p_act: act_cycles=%0d required 1", act_cnt);
        end
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL p_overlap: overlaps=%0d required 0", overlap);
        end
        checks++;
        if (rv_n != 1 || rv_at != 6 || b2.rdata !== 8'h99) begin
            failures++;
            $display("FAIL p_rvalid: pulses=%0d at=%0d rdata=%h required 1 at 6 rdata 99",
                     rv_n, rv_at, b2.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_inputs();
        test_reset_abort();
        test_back_to_back();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter PRE_CYC, default 1: bitline precharge cycles, legal range 1..15.
REQ-002 SHALL have parameter WL_CYC, default 2: wordline-active cycles per access, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req  input  1  access request; sampled only when ready=1.
REQ-006 SHALL have port we  input  1  1=write, 0=read; qualified by req.
REQ-007 SHALL have port addr  input  3  word address, 0..7.
REQ-008 SHALL have port wdata  input  8  write data.
REQ-009 SHALL have port sa_q  input  8  sense-amplifier outputs from the 8x8 array.
REQ-010 SHALL have port ready  output  1  controller idle, accepting a request.
REQ-011 SHALL have port dec_a  output  3  address to the 3x8 wordline decoder.
REQ-012 SHALL have port dec_en  output  1  decoder enable (wordline fire).
REQ-013 SHALL have port pre  output  1  bitline precharge enable.
REQ-014 SHALL have port wen  output  1  write-driver enable.
REQ-015 SHALL have port din  output  8  data to write drivers.
REQ-016 SHALL have port sae  output  1  sense-amp enable.
REQ-017 SHALL have port rdata  output  8  captured read data.
REQ-018 SHALL have port rvalid  output  1  one-cycle pulse: rdata valid.
REQ-019 SHALL have port wdone  output  1  one-cycle pulse: write complete.

Function
REQ-020 SHALL implement FSM states IDLE, PRE, ACT, SENSE, DONE; all control outputs Moore-decoded from registered state (no combinational path from inputs to outputs).
REQ-021 SHALL assert ready only in IDLE.
REQ-022 SHALL, in IDLE on a clock edge with req=1 and rst_n=1, latch addr, we and wdata and enter PRE; req=0 stays IDLE.
REQ-023 SHALL ignore req, we, addr and wdata outside IDLE; the requester holds req until ready.
REQ-024 SHALL drive pre=1 for exactly PRE_CYC cycles in PRE, then enter ACT.
REQ-025 SHALL drive dec_en=1 for exactly WL_CYC cycles in ACT, plus wen=1 throughout ACT when the latched we=1.
REQ-026 SHALL, after ACT, enter SENSE for a read and DONE for a write.
REQ-027 SHALL hold dec_en=1 and sae=1 for one SENSE cycle, load sa_q into rdata at the SENSE-exit edge, then enter DONE.
REQ-028 SHALL, in DONE, pulse rvalid (read) or wdone (write) for one cycle, then return to IDLE.
REQ-029 SHALL drive dec_a and din from latched values at all times, stable from PRE entry to IDLE return.
REQ-030 SHALL never assert pre together with dec_en, wen or sae.
REQ-031 SHALL hold rdata until the next read's SENSE-exit edge; writes do not alter it.
REQ-032 SHALL use one 4-bit phase counter, reloaded on each state entry; no wrap beyond 15.
REQ-033 SHALL give a read-accept edge T -> rvalid high in cycle T+PRE_CYC+WL_CYC+2 (T+5 at defaults).
REQ-034 SHALL give a write-accept edge T -> wdone high in cycle T+PRE_CYC+WL_CYC+1 (T+4 at defaults).
REQ-035 SHALL have ready rise the cycle after DONE; back-to-back requests are spaced by exactly one IDLE cycle.

Reset
REQ-036 SHALL, on any edge with rst_n=0, enter IDLE from any state, aborting any access in flight.
REQ-037 SHALL reset outputs to: ready=1, dec_a=0, dec_en=0, pre=0, wen=0, din=0, sae=0, rdata=0, rvalid=0, wdone=0.
REQ-038 SHALL not accept a request on an edge where rst_n=0, even if req=1.
REQ-039 SHALL NOT pulse rvalid or wdone for an aborted access, nor update rdata.

Verification
REQ-040 SHALL cover: write addr=5, wdata=0xA5 at T -> pre at T+1, dec_a=5, dec_en=1, wen=1, din=0xA5 at T+2..T+3, wdone=1 only at T+4, ready=1 at T+5.
REQ-041 SHALL cover: read addr=5, sa_q=0x3C during SENSE -> sae=1 at T+4, rvalid=1 and rdata=0x3C at T+5.
REQ-042 SHALL cover: addr changed to 2 and req toggled during ACT -> dec_a stays 5, no second access starts.
REQ-043 SHALL cover: rst_n=0 for one edge during ACT of a write -> next cycle all outputs at reset values, no wdone pulse.
REQ-044 SHALL cover: req held high across two reads (addr 0, then 7) -> exactly one ready cycle between them, rvalid pulses 6 cycles apart.
REQ-045 SHALL cover: PRE_CYC=3, WL_CYC=1 read -> pre high 3 cycles, dec_en high 1 cycle in ACT, rvalid at T+6, pre never overlapping dec_en.
